// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//   Frames command packets out of the UART RX byte stream, checks length and
//   checksum, and hands each good command to the control logic through a
//   valid/ready handshake. After every accepted or rejected frame it answers
//   the host with one ACK or NAK byte on the UART TX side.
//
//   Frame: SOF, CMD, LEN, PAYLOAD[LEN], CHK
//          CHK = (CMD + LEN + sum(PAYLOAD)) mod 256
//
// Ports
//   MAX10_CLK1_50  in   system clock (only clock)
//   reset          in   asynchronous active-low reset
//   rx_data        in   received byte, valid while rx_ready=1
//   rx_ready       in   one-cycle strobe per received byte
//   tx_data        out  response byte (ACK/NAK)
//   tx_start       out  one-cycle strobe launching tx_data
//   tx_busy        in   UART TX busy; tx_start is held off while set
//   cmd_valid      out  command present on cmd_* outputs
//   cmd_ready      in   control logic accepts the command
//   cmd_code       out  CMD byte of the last delivered frame
//   cmd_len        out  payload length of the last delivered frame
//   cmd_payload    out  payload, byte i at [8*i+7:8*i], unused bytes zero
//   err_cnt        out  saturating error counter
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
   parameter logic [7:0] SOF_BYTE    = 8'hA5,
   parameter int         MAX_LEN     = 8,
   parameter int         TIMEOUT_CYC = 5_000_000,
   parameter logic [7:0] ACK_BYTE    = 8'h06,
   parameter logic [7:0] NAK_BYTE    = 8'h15
) (
   input  logic                 MAX10_CLK1_50,
   input  logic                 reset,
   input  logic [7:0]           rx_data,
   input  logic                 rx_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [7:0]           cmd_code,
   output logic [3:0]           cmd_len,
   output logic [8*MAX_LEN-1:0] cmd_payload,
   output logic [7:0]           err_cnt
);

   localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] GET_CMD = 3'd1;
   localparam logic [2:0] GET_LEN = 3'd2;
   localparam logic [2:0] GET_PAY = 3'd3;
   localparam logic [2:0] GET_CHK = 3'd4;
   localparam logic [2:0] DELIVER = 3'd5;
   localparam logic [2:0] RESP    = 3'd6;

   logic [2:0]              state;
   logic [7:0]              code_q;
   logic [3:0]              len_q;
   logic [3:0]              idx;
   logic [7:0]              sum;
   logic [TW-1:0]           timer;
   logic                    resp_nak;
   logic [MAX_LEN-1:0][7:0] pay_buf;   // frame under collection
   logic [MAX_LEN-1:0][7:0] pay_out;   // last delivered frame

   logic in_frame, timeout, sof_acc, len_bad, chk_ok, chk_bad, drop, err_evt;
   logic pay_wr;

   assign cmd_payload = pay_out;

   // ---- event decode -------------------------------------------------------
   always_comb begin
      in_frame = (state == GET_CMD) || (state == GET_LEN) ||
                 (state == GET_PAY) || (state == GET_CHK);
      // A byte arriving on the last permitted cycle still counts: the timer
      // only expires on a cycle with no rx_ready.
      timeout  = in_frame && !rx_ready && (timer == TMO_LAST);
      sof_acc  = (state == IDLE) && rx_ready && (rx_data == SOF_BYTE);
      len_bad  = (state == GET_LEN) && rx_ready && (rx_data > MAX_LEN_B);
      chk_ok   = (state == GET_CHK) && rx_ready && (rx_data == sum);
      chk_bad  = (state == GET_CHK) && rx_ready && (rx_data != sum);
      pay_wr   = (state == GET_PAY) && rx_ready;
      // A frame cannot start while the previous one is still being answered.
      drop     = rx_ready && ((state == DELIVER) || (state == RESP));
      // Sources are mutually exclusive per cycle, but OR them anyway so the
      // counter can never step by more than one.
      err_evt  = timeout || len_bad || chk_bad || drop;
   end

   // ---- control FSM --------------------------------------------------------
   always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         code_q    <= '0;
         len_q     <= '0;
         idx       <= '0;
         sum       <= '0;
         timer     <= '0;
         resp_nak  <= 1'b0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_code  <= '0;
         cmd_len   <= '0;
         err_cnt   <= '0;
      end else begin
         tx_start <= 1'b0;

         if (err_evt && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;

         if (in_frame && !rx_ready)
            timer <= timer + TW'(1);
         else
            timer <= '0;

         case (state)
            IDLE: begin
               if (sof_acc) begin
                  idx   <= '0;
                  sum   <= '0;
                  state <= GET_CMD;
               end
            end

            GET_CMD: begin
               if (timeout)
                  state <= IDLE;
               else if (rx_ready) begin
                  code_q <= rx_data;
                  sum    <= rx_data;
                  state  <= GET_LEN;
               end
            end

            GET_LEN: begin
               if (timeout)
                  state <= IDLE;
               else if (len_bad) begin
                  resp_nak <= 1'b1;
                  state    <= RESP;
               end else if (rx_ready) begin
                  len_q <= rx_data[3:0];
                  sum   <= sum + rx_data;
                  state <= (rx_data == 8'd0) ? GET_CHK : GET_PAY;
               end
            end

            GET_PAY: begin
               if (timeout)
                  state <= IDLE;
               else if (rx_ready) begin
                  sum <= sum + rx_data;
                  idx <= idx + 4'd1;
                  if (idx + 4'd1 == len_q)
                     state <= GET_CHK;
               end
            end

            GET_CHK: begin
               if (timeout)
                  state <= IDLE;
               else if (chk_ok) begin
                  cmd_valid <= 1'b1;
                  cmd_code  <= code_q;
                  cmd_len   <= len_q;
                  state     <= DELIVER;
               end else if (chk_bad) begin
                  resp_nak <= 1'b1;
                  state    <= RESP;
               end
            end

            DELIVER: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  resp_nak  <= 1'b0;
                  state     <= RESP;
               end
            end

            RESP: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= resp_nak ? NAK_BYTE : ACK_BYTE;
                  resp_nak <= 1'b0;
                  state    <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // ---- payload byte lanes -------------------------------------------------
   // The collection buffer is wiped at SOF so bytes beyond LEN are already
   // zero when the frame is copied to the output register.
   always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
      if (!reset) begin
         pay_buf <= '0;
         pay_out <= '0;
      end else begin
         for (int i = 0; i < MAX_LEN; i++) begin
            if (sof_acc)
               pay_buf[i] <= '0;
            else if (pay_wr && (idx == 4'(i)))
               pay_buf[i] <= rx_data;
            if (chk_ok)
               pay_out[i] <= pay_buf[i];
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_parser
//   Directed vectors for uart_cmd_parser with hand-computed expectations.
//   Uses a short timeout so the idle-timeout path is reachable quickly.
// ---------------------------------------------------------------------------
module tb_uart_cmd_parser;

   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_ready = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy = 1'b0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b1;
   logic [7:0]  cmd_code;
   logic [3:0]  cmd_len;
   logic [63:0] cmd_payload;
   logic [7:0]  err_cnt;

   int n_vec = 0;
   int n_err = 0;
   int tx_cnt = 0;
   logic [7:0] last_tx = '0;
   int cv_cnt = 0;
   int hold_cnt;

   uart_cmd_parser #(
      .SOF_BYTE   (8'hA5),
      .MAX_LEN    (8),
      .TIMEOUT_CYC(TMO),
      .ACK_BYTE   (8'h06),
      .NAK_BYTE   (8'h15)
   ) dut (
      .MAX10_CLK1_50(clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_busy      (tx_busy),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_code     (cmd_code),
      .cmd_len      (cmd_len),
      .cmd_payload  (cmd_payload),
      .err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   // Count response strobes and valid cycles seen on the falling edge.
   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         tx_cnt  = tx_cnt + 1;
         last_tx = tx_data;
      end
      if (cmd_valid === 1'b1)
         cv_cnt = cv_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic clr_mon();
      tx_cnt  = 0;
      cv_cnt  = 0;
      last_tx = '0;
   endtask

   initial begin
      // ---- reset state ----
      #1 reset = 1'b0;
      #1;
      chk("rst_valid",  64'(cmd_valid), 64'd0);
      chk("rst_txst",   64'(tx_start),  64'd0);
      chk("rst_txdata", 64'(tx_data),   64'd0);
      chk("rst_err",    64'(err_cnt),   64'd0);
      chk("rst_pay",    cmd_payload,    64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // ---- 1: good frame, immediate accept ----
      clr_mon();
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h45);
      chk("t1_valid_lat", 64'(cmd_valid),   64'd1);
      chk("t1_code",      64'(cmd_code),    64'h10);
      chk("t1_len",       64'(cmd_len),     64'd2);
      chk("t1_pay",       cmd_payload,      64'h2211);
      @(negedge clk);
      chk("t1_valid_drop", 64'(cmd_valid),  64'd0);
      @(negedge clk);
      chk("t1_txst",   64'(tx_start), 64'd1);
      chk("t1_txdata", 64'(tx_data),  64'h06);
      repeat (4) @(negedge clk);
      chk("t1_txcnt",  64'(tx_cnt),   64'd1);
      chk("t1_cvcnt",  64'(cv_cnt),   64'd1);

      // ---- 2: bad checksum ----
      clr_mon();
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h46);
      repeat (5) @(negedge clk);
      chk("t2_cvcnt", 64'(cv_cnt),  64'd0);
      chk("t2_txcnt", 64'(tx_cnt),  64'd1);
      chk("t2_nak",   64'(last_tx), 64'h15);
      chk("t2_err",   64'(err_cnt), 64'd1);
      chk("t2_hold_code", 64'(cmd_code), 64'h10);
      chk("t2_hold_pay",  cmd_payload,   64'h2211);

      // ---- 3: length over limit, then junk in IDLE ----
      clr_mon();
      send_byte(8'hA5); send_byte(8'h07); send_byte(8'h09);
      repeat (4) @(negedge clk);
      chk("t3_nak",   64'(last_tx), 64'h15);
      chk("t3_err",   64'(err_cnt), 64'd2);
      send_byte(8'h10); send_byte(8'h00); send_byte(8'h10);
      repeat (4) @(negedge clk);
      chk("t3_junk_err", 64'(err_cnt), 64'd2);
      chk("t3_txcnt",    64'(tx_cnt),  64'd1);
      chk("t3_cvcnt",    64'(cv_cnt),  64'd0);

      // ---- 4: inter-byte timeout ----
      clr_mon();
      send_byte(8'hA5); send_byte(8'h03);
      repeat (TMO - 5) @(negedge clk);
      chk("t4_pre_tmo_err", 64'(err_cnt), 64'd2);
      repeat (10) @(negedge clk);
      chk("t4_tmo_err", 64'(err_cnt), 64'd3);
      chk("t4_no_tx",   64'(tx_cnt),  64'd0);
      // gaps below the limit between every byte must not expire
      send_byte(8'hA5); send_byte(8'h03);
      repeat (150) @(negedge clk);
      send_byte(8'h00);
      repeat (150) @(negedge clk);
      send_byte(8'h03);
      chk("t4_valid", 64'(cmd_valid), 64'd1);
      repeat (4) @(negedge clk);
      chk("t4_ack",   64'(last_tx),   64'h06);
      chk("t4_code",  64'(cmd_code),  64'h03);
      chk("t4_len",   64'(cmd_len),   64'd0);
      chk("t4_pay0",  cmd_payload,    64'd0);
      chk("t4_err",   64'(err_cnt),   64'd3);

      // ---- 5: back-pressure on both handshakes ----
      clr_mon();
      cmd_ready = 1'b0;
      tx_busy   = 1'b1;
      send_byte(8'hA5); send_byte(8'h20); send_byte(8'h03);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      send_byte(8'h29);
      hold_cnt = 0;
      repeat (20) begin
         if (cmd_valid && cmd_code == 8'h20 && cmd_len == 4'd3 &&
             cmd_payload == 64'h030201)
            hold_cnt++;
         @(negedge clk);
      end
      chk("t5_hold", 64'(hold_cnt), 64'd20);
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("t5_valid_drop", 64'(cmd_valid), 64'd0);
      cmd_ready = 1'b1;
      repeat (50) @(negedge clk);
      send_byte(8'hA5);            // dropped while waiting to respond
      repeat (48) @(negedge clk);
      chk("t5_busy_no_tx", 64'(tx_cnt),  64'd0);
      chk("t5_drop_err",   64'(err_cnt), 64'd4);
      tx_busy = 1'b0;
      chk("t5_txst_pre", 64'(tx_start), 64'd0);
      @(negedge clk);
      chk("t5_txst",   64'(tx_start), 64'd1);
      chk("t5_txdata", 64'(tx_data),  64'h06);
      repeat (5) @(negedge clk);
      chk("t5_txcnt",  64'(tx_cnt),   64'd1);
      chk("t5_code_hold", 64'(cmd_code), 64'h20);

      // ---- 6a: reset in the middle of payload ----
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_rst_err",  64'(err_cnt),  64'd0);
      chk("t6_rst_code", 64'(cmd_code), 64'd0);
      chk("t6_rst_pay",  cmd_payload,   64'd0);
      chk("t6_rst_tx",   64'(tx_data),  64'd0);
      @(negedge clk);
      reset = 1'b1;

      // ---- 6b: reset while waiting to respond ----
      clr_mon();
      tx_busy = 1'b1;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_resp_code",  64'(cmd_code),  64'd0);
      chk("t6_resp_valid", 64'(cmd_valid), 64'd0);
      @(negedge clk);
      reset   = 1'b1;
      tx_busy = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_no_resp", 64'(tx_cnt), 64'd0);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
      repeat (4) @(negedge clk);
      chk("t6_ack_cnt", 64'(tx_cnt),  64'd1);
      chk("t6_ack",     64'(last_tx), 64'h06);

      // ---- 6c: error counter saturation ----
      for (int i = 0; i < 254; i++) begin
         send_byte(8'hA5); send_byte(8'h00); send_byte(8'h09);
         repeat (2) @(negedge clk);
      end
      chk("t6_err_fe", 64'(err_cnt), 64'hFE);
      for (int i = 0; i < 46; i++) begin
         send_byte(8'hA5); send_byte(8'h00); send_byte(8'h09);
         repeat (2) @(negedge clk);
      end
      chk("t6_err_sat", 64'(err_cnt), 64'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
